// File: rtl/gemm_row_loader_if.sv
// Command, SRAM-read and FIFO-push signals of one bank's GEMM row loader.
// master = the loader itself, slave = the bank environment driving it.
interface gemm_row_loader_if #(
  parameter int BITS_PER_ROW = 64,
  parameter int MAT_S_W      = 3,
  parameter int ROW_S_W      = 2,
  parameter int FREE_W       = 4
);
  logic                                    cmd_valid;
  logic                                    cmd_ready;
  logic [MAT_S_W-1:0]                      cmd_weight_mat;
  logic [MAT_S_W-1:0]                      cmd_input_mat;
  logic [MAT_S_W-1:0]                      cmd_partial_mat;
  logic                                    cmd_new_weight;
  logic                                    cmd_partial_en;
  logic                                    sram_ren;
  logic [MAT_S_W+ROW_S_W-1:0]              sram_addr;
  logic [BITS_PER_ROW-1:0]                 sram_rdata;
  logic [FREE_W-1:0]                       fifo_free;
  logic                                    fifo_wen;
  logic [BITS_PER_ROW+MAT_S_W+ROW_S_W+1:0] fifo_wdata;
  logic                                    busy;
  logic                                    done;

  modport master (
    input  cmd_valid, cmd_weight_mat, cmd_input_mat, cmd_partial_mat,
           cmd_new_weight, cmd_partial_en, sram_rdata, fifo_free,
    output cmd_ready, sram_ren, sram_addr, fifo_wen, fifo_wdata, busy, done
  );

  modport slave (
    output cmd_valid, cmd_weight_mat, cmd_input_mat, cmd_partial_mat,
           cmd_new_weight, cmd_partial_en, sram_rdata, fifo_free,
    input  cmd_ready, sram_ren, sram_addr, fifo_wen, fifo_wdata, busy, done
  );
endinterface

// File: rtl/gemm_row_loader.sv
// Reads weight/input/partial rows for a GEMM command and pushes tagged rows into the bank FIFO.
// One read per cycle while FIFO credit allows; each row is pushed SRAM_LAT cycles after its read.
module gemm_row_loader #(
  parameter int BITS_PER_ROW = 64,
  parameter int MAT_S_W      = 3,
  parameter int ROW_S_W      = 2,
  parameter int SRAM_LAT     = 2,
  parameter int FREE_W       = 4
) (
  input  logic              CLK,
  input  logic              RST,
  gemm_row_loader_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_WEIGHT, S_INPUT, S_PARTIAL, S_DRAIN} state_t;

  typedef struct packed {
    logic               vld;
    logic [1:0]         typ;
    logic [MAT_S_W-1:0] mat;
    logic [ROW_S_W-1:0] row;
  } tag_t;

  state_t             state_q, state_d;
  logic [ROW_S_W-1:0] row_q, row_d;
  logic [MAT_S_W-1:0] wmat_q, wmat_d;
  logic [MAT_S_W-1:0] imat_q, imat_d;
  logic [MAT_S_W-1:0] pmat_q, pmat_d;
  logic               pen_q, pen_d;
  logic [FREE_W-1:0]  outstanding_q, outstanding_d;
  tag_t               pipe_q [SRAM_LAT];
  tag_t               pipe_d [SRAM_LAT];

  logic               phase;
  logic [1:0]         phase_typ;
  logic [MAT_S_W-1:0] phase_mat;
  logic               ren;
  logic               wen;
  logic               done;
  tag_t               pipe_out;

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    wmat_d    = wmat_q;
    imat_d    = imat_q;
    pmat_d    = pmat_q;
    pen_d     = pen_q;
    phase     = 1'b0;
    phase_typ = 2'b00;
    phase_mat = '0;
    done      = 1'b0;
    pipe_out  = pipe_q[SRAM_LAT-1];
    wen       = pipe_out.vld;

    case (state_q)
      S_WEIGHT:  begin phase = 1'b1; phase_typ = 2'b00; phase_mat = wmat_q; end
      S_INPUT:   begin phase = 1'b1; phase_typ = 2'b01; phase_mat = imat_q; end
      S_PARTIAL: begin phase = 1'b1; phase_typ = 2'b10; phase_mat = pmat_q; end
      default:   ;
    endcase

    // Credit check: every row in flight already owns a FIFO slot.
    ren = phase && (outstanding_q < bus.fifo_free);

    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          wmat_d  = bus.cmd_weight_mat;
          imat_d  = bus.cmd_input_mat;
          pmat_d  = bus.cmd_partial_mat;
          pen_d   = bus.cmd_partial_en;
          row_d   = '0;
          state_d = bus.cmd_new_weight ? S_WEIGHT : S_INPUT;
        end
      end
      S_WEIGHT, S_INPUT, S_PARTIAL: begin
        if (ren) begin
          row_d = row_q + ROW_S_W'(1);
          if (row_q == '1) begin
            row_d = '0;
            case (state_q)
              S_WEIGHT: state_d = S_INPUT;
              S_INPUT:  state_d = pen_q ? S_PARTIAL : S_DRAIN;
              default:  state_d = S_DRAIN;
            endcase
          end
        end
      end
      S_DRAIN: begin
        if (outstanding_q == '0 && !wen) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    outstanding_d = outstanding_q;
    if (ren && !wen) outstanding_d = outstanding_q + FREE_W'(1);
    else if (!ren && wen) outstanding_d = outstanding_q - FREE_W'(1);

    pipe_d[0].vld = ren;
    pipe_d[0].typ = phase_typ;
    pipe_d[0].mat = phase_mat;
    pipe_d[0].row = row_q;
    for (int i = 1; i < SRAM_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      wmat_q        <= '0;
      imat_q        <= '0;
      pmat_q        <= '0;
      pen_q         <= 1'b0;
      outstanding_q <= '0;
      for (int i = 0; i < SRAM_LAT; i++) pipe_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      row_q         <= row_d;
      wmat_q        <= wmat_d;
      imat_q        <= imat_d;
      pmat_q        <= pmat_d;
      pen_q         <= pen_d;
      outstanding_q <= outstanding_d;
      for (int i = 0; i < SRAM_LAT; i++) pipe_q[i] <= pipe_d[i];
    end
  end

  assign bus.cmd_ready  = (state_q == S_IDLE);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = done;
  assign bus.sram_ren   = ren;
  assign bus.sram_addr  = ren ? {phase_mat, row_q} : '0;
  assign bus.fifo_wen   = wen;
  assign bus.fifo_wdata = wen ? {pipe_out.typ, pipe_out.mat, pipe_out.row, bus.sram_rdata} : '0;

endmodule
